// File: rtl/dm_pkg.sv
// Debug-module package: the abstract-command encodings shared by the CSR
// decode, the abstract-command controller and the instruction generator.
//   cmd_t        abstract command type (Command.cmdtype)
//   command_t    raw Command register layout
//   ac_ar_cmd_t  AccessRegister control field layout
//   cmderr_t     abstractcs.cmderr encoding
//   abs_state_e  abstract-command controller state
package dm;

  typedef enum logic [7:0] {
    AccessRegister = 8'h00,
    QuickAccess    = 8'h01,
    AccessMemory   = 8'h02
  } cmd_t;

  typedef struct packed {
    cmd_t        cmdtype;
    logic [23:0] control;
  } command_t;

  typedef struct packed {
    logic        zero1;
    logic [2:0]  aarsize;
    logic        aarpostincrement;
    logic        postexec;
    logic        transfer;
    logic        write;
    logic [15:0] regno;
  } ac_ar_cmd_t;

  typedef enum logic [2:0] {
    CmdErrNone         = 3'h0,
    CmdErrBusy         = 3'h1,
    CmdErrNotSupported = 3'h2,
    CmdErrorException  = 3'h3,
    CmdErrorHaltResume = 3'h4,
    CmdErrorBus        = 3'h5,
    CmdErrorOther      = 3'h7
  } cmderr_t;

  localparam logic [15:0] RegnoCsrMax  = 16'h0FFF;
  localparam logic [15:0] RegnoGprBase = 16'h1000;
  localparam logic [15:0] RegnoGprMax  = 16'h101F;

  typedef enum logic [1:0] {
    CmdIdle = 2'd0,
    CmdGo   = 2'd1,
    CmdExec = 2'd2
  } abs_state_e;

  // A register number is reachable if it is a CSR or one of the 32 GPRs.
  function automatic logic regno_supported(input logic [15:0] regno);
    logic csr_ok;
    logic gpr_ok;
    csr_ok = (regno <= RegnoCsrMax);
    gpr_ok = (regno >= RegnoGprBase) && (regno <= RegnoGprMax);
    return csr_ok | gpr_ok;
  endfunction

endpackage

// File: rtl/dm_abstract_ctrl.sv
// Abstract-command controller. Validates a Command write against the
// supported AccessRegister subset, hands the hart a go request, waits for it
// to be consumed and for the program to finish, and keeps abstractcs.busy and
// the sticky abstractcs.cmderr field. Both waiting states are guarded by a
// timeout so a hart that never answers cannot wedge the debug module.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   dmactive_i           dmcontrol.dmactive; low soft-resets the block
//   cmd_valid_i, cmd_i   Command write pulse and data
//   cmderr_clr_i,
//   cmderr_clr_val_i     abstractcs write pulse and W1C cmderr value
//   halted_i             selected hart is parked
//   going_i              hart consumed go
//   done_i               hart finished the abstract program
//   exception_i          hart trapped during the abstract program
//   go_o                 run request to the hart
//   busy_o               abstractcs.busy
//   cmderr_o             abstractcs.cmderr
//   cmd_o                AccessRegister command latched at acceptance
module dm_abstract_ctrl
  import dm::*;
#(
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dmactive_i,
  input  logic        cmd_valid_i,
  input  logic [31:0] cmd_i,
  input  logic        cmderr_clr_i,
  input  logic [2:0]  cmderr_clr_val_i,
  input  logic        halted_i,
  input  logic        going_i,
  input  logic        done_i,
  input  logic        exception_i,
  output logic        go_o,
  output logic        busy_o,
  output cmderr_t     cmderr_o,
  output logic [31:0] cmd_o
);

  localparam int unsigned TimerW = $clog2(TimeoutCycles);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TimeoutCycles - 1);

  abs_state_e        state_q, state_d;
  cmderr_t           cmderr_q, cmderr_d;
  logic [31:0]       cmd_q, cmd_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              go_q;
  logic              busy_q;

  command_t   cmd_s;
  ac_ar_cmd_t ar_s;
  logic       err_none_s;
  logic       clr_hit_s;

  assign cmd_s      = command_t'(cmd_i);
  assign ar_s       = ac_ar_cmd_t'(cmd_s.control);
  assign err_none_s = (cmderr_q == CmdErrNone);
  assign clr_hit_s  = cmderr_clr_i && ((cmderr_clr_val_i & cmderr_q) != 3'b000);

  // Next-state, error and latched-command logic.
  always_comb begin
    state_d  = state_q;
    cmderr_d = cmderr_q;
    cmd_d    = cmd_q;
    timer_d  = timer_q;

    // The clear is applied first so that any error raised below wins.
    if (clr_hit_s) begin
      cmderr_d = CmdErrNone;
    end else begin
      cmderr_d = cmderr_q;
    end

    case (state_q)
      CmdIdle: begin
        // A pending error blocks every new command until it is cleared.
        if (cmd_valid_i && err_none_s) begin
          if (cmd_s.cmdtype != AccessRegister) begin
            cmderr_d = CmdErrNotSupported;
          end else if (ar_s.aarsize > 3'd3) begin
            cmderr_d = CmdErrNotSupported;
          end else if (ar_s.transfer && !regno_supported(ar_s.regno)) begin
            cmderr_d = CmdErrNotSupported;
          end else if (!halted_i) begin
            cmderr_d = CmdErrorHaltResume;
          end else begin
            cmd_d   = {8'h00, cmd_i[23:0]};
            state_d = CmdGo;
            timer_d = '0;
          end
        end else begin
          state_d = CmdIdle;
        end
      end

      CmdGo: begin
        if (cmd_valid_i && err_none_s) begin
          cmderr_d = CmdErrBusy;
        end else begin
          state_d = CmdGo;
        end
        if (going_i) begin
          state_d = CmdExec;
          timer_d = '0;
        end else if (timer_q == TimerLast) begin
          state_d = CmdIdle;
          if (err_none_s) begin
            cmderr_d = CmdErrorOther;
          end else begin
            state_d = CmdIdle;
          end
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end

      CmdExec: begin
        if (cmd_valid_i && err_none_s) begin
          cmderr_d = CmdErrBusy;
        end else begin
          state_d = CmdExec;
        end
        // Exception is checked ahead of done so a simultaneous pair reports it.
        if (exception_i) begin
          cmderr_d = CmdErrorException;
          state_d  = CmdIdle;
        end else if (done_i) begin
          state_d = CmdIdle;
        end else if (timer_q == TimerLast) begin
          state_d = CmdIdle;
          if (err_none_s) begin
            cmderr_d = CmdErrorOther;
          end else begin
            state_d = CmdIdle;
          end
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end

      default: begin
        state_d = CmdIdle;
      end
    endcase
  end

  // State and output registers; go/busy are derived from the next state so
  // they change on the same edge as the state they describe.
  always_ff @(posedge clk_i) begin
    if (rst_i || !dmactive_i) begin
      state_q  <= CmdIdle;
      cmderr_q <= CmdErrNone;
      cmd_q    <= 32'h0000_0000;
      timer_q  <= '0;
      go_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmderr_q <= cmderr_d;
      cmd_q    <= cmd_d;
      timer_q  <= timer_d;
      go_q     <= (state_d == CmdGo);
      busy_q   <= (state_d != CmdIdle);
    end
  end

  assign go_o     = go_q;
  assign busy_o   = busy_q;
  assign cmderr_o = cmderr_q;
  assign cmd_o    = cmd_q;

endmodule

// File: doc/dm_abstract_ctrl.md
# dm_abstract_ctrl

Abstract-command controller for the debug module. It accepts a write to the `Command` register, checks it against the supported `AccessRegister` subset, and sequences the selected hart through go, execute and return. It also maintains the `busy` and sticky `cmderr` fields of `abstractcs`. It sits between the DMI-facing CSR decode and the hart-facing go/halted handshake, and latches the command for the abstract-instruction generator.

## Interface
- `TimeoutCycles`, default 1024: cycles allowed in each of Go and Exec before abort; must be ≥ 2.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `dmactive_i`  in  1  `dmcontrol.dmactive`; low acts as a synchronous soft reset of the block.
- `cmd_valid_i`  in  1  one-cycle pulse on a DMI write to `Command` (or an autoexec trigger).
- `cmd_i`  in  32  `dm::command_t` written with the pulse.
- `cmderr_clr_i`  in  1  pulse on a DMI write to `abstractcs`.
- `cmderr_clr_val_i`  in  3  written `cmderr` field (W1C).
- `halted_i`  in  1  selected hart is parked in the debug loop.
- `going_i`  in  1  one-cycle pulse: hart consumed go.
- `done_i`  in  1  one-cycle pulse: hart finished the abstract program and is parked again.
- `exception_i`  in  1  one-cycle pulse: hart trapped while executing.
- `go_o`  out  1  request to the hart to run the abstract program.
- `busy_o`  out  1  `abstractcs.busy`.
- `cmderr_o`  out  3  `dm::cmderr_t`.
- `cmd_o`  out  32  `dm::ac_ar_cmd_t` latched at acceptance.

## Operation
- States: IDLE, GO, EXEC.
- Reset values (`rst_i`, or `dmactive_i`=0): state IDLE, `go_o`=0, `busy_o`=0, `cmderr_o`=CmdErrNone, `cmd_o`=0, timer 0.
- In IDLE, a `cmd_valid_i` is evaluated against the registered `cmderr_o`. Checks run in this order:
  - `cmderr_o`≠None: the command is ignored and nothing changes.
  - `cmdtype`≠AccessRegister: error NotSupported.
  - `aarsize`>3: error NotSupported.
  - `transfer`=1 and `regno` outside 0x0000–0x0FFF (CSR) or 0x1000–0x101F (GPR): error NotSupported.
  - `halted_i`=0: error HaltResume.
  - Otherwise: `cmd_o` ← `cmd_i[23:0]`, state → GO.
- GO: `go_o`=1. On `going_i`, state → EXEC and `go_o` drops the next cycle.
- EXEC: on `done_i`, state → IDLE. On `exception_i`, `cmderr_o` ← Exception and state → IDLE. If both arrive together, the exception wins.
- `busy_o` = (state≠IDLE). The output is registered and is consistent with state.
- `cmd_valid_i` in GO or EXEC: if `cmderr_o`=None, set Busy. The command is dropped and the state is unchanged.
- Timeout: a timer clears on entry to GO and on entry to EXEC, and increments each cycle in GO and EXEC. When it reaches `TimeoutCycles`-1 without the awaited pulse: `cmderr_o` ← Other (if None), state → IDLE, `go_o` ← 0.
- Clearing `cmderr`: `cmderr_clr_i` clears `cmderr_o` to None when `cmderr_clr_val_i` has any bit set where `cmderr_o` is nonzero, i.e. `(cmderr_clr_val_i & cmderr_o)`≠0. Otherwise there is no change.
- If a new error is set in the same cycle as a clear, the new error wins.

## Timing
- `cmd_valid_i` at cycle N, accepted: `go_o`=1 and `busy_o`=1 at N+1.
- `going_i` at M: `go_o`=0 at M+1.
- `done_i` or `exception_i` at K: `busy_o`=0 at K+1, and `cmderr_o` is updated at K+1.
- A rejected command updates `cmderr_o` at N+1, and `busy_o` stays 0.
- Shortest command: accept at N, `going_i` at N+1, `done_i` at N+2, so `busy_o` is high for cycles N+1 to N+2.
- `dmactive_i` falling mid-command: the block is in IDLE the next cycle with all outputs at reset values. A later `done_i` is ignored.
- `going_i`/`done_i` outside their own state: ignored.
- `exception_i` outside EXEC: ignored.

## Structure
- Add to package `dm`:
  - `RegnoCsrMax`=16'h0FFF, `RegnoGprBase`=16'h1000, `RegnoGprMax`=16'h101F.
  - `typedef enum logic [1:0] {CmdIdle, CmdGo, CmdExec} abs_state_e`.
- Reuse the existing `command_t`, `ac_ar_cmd_t`, `cmderr_t` and `cmd_t` from `dm`.
- Single module, no sub-modules. The timeout counter is inline with width `$clog2(TimeoutCycles)`.

## Test plan
- Halted hart, `cmd_i`=0x0032_1001 (AccessRegister, aarsize 3, transfer 1, regno 0x1001): `busy_o` and `go_o` rise next cycle. `going_i` 3 cycles later, then `done_i` 2 cycles later: `busy_o` falls, `cmderr_o`=0, `cmd_o`=0x32_1001.
- `cmd_i`=0x0200_0000 (AccessMemory): `cmderr_o`=2 and `busy_o` stays 0. A second, valid command is ignored. Clear with 3'b111 gives `cmderr_o`=0, and a retry succeeds.
- Running hart (`halted_i`=0) with a valid command: `cmderr_o`=4. Clear with 3'b001 leaves 4; clear with 3'b100 gives 0.
- Command in EXEC: `cmderr_o`=1 and the original command still completes on `done_i`. `exception_i` and `done_i` in the same cycle: `cmderr_o`=3.
- `TimeoutCycles`=8, `going_i` never asserted: `cmderr_o`=7 and `busy_o`=0 exactly 8 cycles after `go_o` rose.
- `dmactive_i` driven low in EXEC with `cmderr_o`=1: next cycle all outputs are 0 and a subsequent `done_i` has no effect.
